// File: rtl/rv32_pkg.sv
// Shared RV32I control definitions: opcode constants, funct3 codes and the
// enumerations used by the multicycle instruction sequencer.
// Build option: EBREAK_HALT_EN adds the HALT state used by EBREAK.
package rv32_pkg;

  // Major opcodes (ir[6:0])
  localparam logic [6:0] ITYPE   = 7'b0010011;  // OP-IMM
  localparam logic [6:0] ITYPE_L = 7'b0000011;  // LOAD
  localparam logic [6:0] ITYPE_J = 7'b1100111;  // JALR
  localparam logic [6:0] ITYPE_E = 7'b1110011;  // SYSTEM
  localparam logic [6:0] STYPE   = 7'b0100011;  // STORE
  localparam logic [6:0] BTYPE   = 7'b1100011;  // BRANCH
  localparam logic [6:0] UTYPE_L = 7'b0110111;  // LUI
  localparam logic [6:0] UTYPE_A = 7'b0010111;  // AUIPC
  localparam logic [6:0] JTYPE   = 7'b1101111;  // JAL
  localparam logic [6:0] RTYPE   = 7'b0110011;  // OP

  // Shift-immediate funct3 codes; these take a shamt instead of an I immediate
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRLI = 3'b101;

`ifdef EBREAK_HALT_EN
  typedef enum logic [3:0] {
    ST_RESET   = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_EXECUTE = 4'd3,
    ST_MEM_RD  = 4'd4,
    ST_MEM_WR  = 4'd5,
    ST_WB      = 4'd6,
    ST_TRAP    = 4'd7,
    ST_HALT    = 4'd8
  } state_t;
`else
  typedef enum logic [3:0] {
    ST_RESET   = 4'd0,
    ST_FETCH   = 4'd1,
    ST_DECODE  = 4'd2,
    ST_EXECUTE = 4'd3,
    ST_MEM_RD  = 4'd4,
    ST_MEM_WR  = 4'd5,
    ST_WB      = 4'd6,
    ST_TRAP    = 4'd7
  } state_t;
`endif

  typedef enum logic [2:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_U     = 3'd3,
    IMM_J     = 3'd4,
    IMM_SHAMT = 3'd5,
    IMM_ZERO  = 3'd7
  } imm_sel_t;

  // ALU operand A source
  typedef enum logic [1:0] {
    ALU_A_PC     = 2'd0,
    ALU_A_RS1    = 2'd1,
    ALU_A_OLD_PC = 2'd2
  } alu_src_t;

  // ALU operand B source
  typedef enum logic [1:0] {
    ALU_B_RS2  = 2'd0,
    ALU_B_IMM  = 2'd1,
    ALU_B_FOUR = 2'd2
  } alu_b_src_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2
  } alu_op_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_t;

  // Instruction class latched in DECODE and used to steer EXECUTE/WB
  typedef enum logic [3:0] {
    CLS_ALU     = 4'd0,
    CLS_LOAD    = 4'd1,
    CLS_STORE   = 4'd2,
    CLS_BRANCH  = 4'd3,
    CLS_JAL     = 4'd4,
    CLS_JALR    = 4'd5,
    CLS_UPPER   = 4'd6,
    CLS_SYSTEM  = 4'd7,
    CLS_EBREAK  = 4'd8,
    CLS_ILLEGAL = 4'd9
  } op_class_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Control bundle between the instruction sequencer (master) and the datapath
// (slave): decode inputs, memory handshake and all datapath select outputs.
interface instr_sequencer_if;
  logic [31:0] ir_i;
  logic        mem_rdy_i;
  logic        branch_take_i;
  logic        resume_i;
  logic        pc_ld_o;
  logic        ir_ld_o;
  logic        mem_rd_o;
  logic        mem_wr_o;
  logic        addr_src_o;
  logic [1:0]  alu_a_src_o;
  logic [1:0]  alu_b_src_o;
  logic [1:0]  alu_op_o;
  logic [2:0]  imm_sel_o;
  logic [1:0]  result_src_o;
  logic        rf_wr_o;
  logic        illegal_o;
  logic        halted_o;

  modport master (
    input  ir_i, mem_rdy_i, branch_take_i, resume_i,
    output pc_ld_o, ir_ld_o, mem_rd_o, mem_wr_o, addr_src_o, alu_a_src_o,
           alu_b_src_o, alu_op_o, imm_sel_o, result_src_o, rf_wr_o,
           illegal_o, halted_o
  );

  modport slave (
    output ir_i, mem_rdy_i, branch_take_i, resume_i,
    input  pc_ld_o, ir_ld_o, mem_rd_o, mem_wr_o, addr_src_o, alu_a_src_o,
           alu_b_src_o, alu_op_o, imm_sel_o, result_src_o, rf_wr_o,
           illegal_o, halted_o
  );
endinterface

// File: rtl/opcode_classifier.sv
// Combinational RV32I opcode classifier: maps the instruction word to an
// instruction class and the immediate-mux select used in DECODE.
module opcode_classifier
  import rv32_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] ir,
  output op_class_t             op_class,
  output imm_sel_t              imm_sel
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic       is_shift_s;
  logic       unused_s;

  assign opcode_s   = ir[6:0];
  assign funct3_s   = ir[14:12];
  assign is_shift_s = (funct3_s == F3_SLLI) || (funct3_s == F3_SRLI);
  assign unused_s   = ^{ir[DATA_WIDTH-1:21], ir[19:15], ir[11:7]};

  // Opcode decode; anything not listed is classed illegal with a zero immediate
  always_comb begin
    op_class = CLS_ILLEGAL;
    imm_sel  = IMM_ZERO;
    case (opcode_s)
      RTYPE:   begin op_class = CLS_ALU;    imm_sel = IMM_ZERO; end
      ITYPE:   begin op_class = CLS_ALU;    imm_sel = is_shift_s ? IMM_SHAMT : IMM_I; end
      ITYPE_L: begin op_class = CLS_LOAD;   imm_sel = IMM_I; end
      ITYPE_J: begin op_class = CLS_JALR;   imm_sel = IMM_I; end
      ITYPE_E: begin op_class = ir[20] ? CLS_EBREAK : CLS_SYSTEM; imm_sel = IMM_I; end
      STYPE:   begin op_class = CLS_STORE;  imm_sel = IMM_S; end
      BTYPE:   begin op_class = CLS_BRANCH; imm_sel = IMM_B; end
      UTYPE_L: begin op_class = CLS_UPPER;  imm_sel = IMM_U; end
      UTYPE_A: begin op_class = CLS_UPPER;  imm_sel = IMM_U; end
      JTYPE:   begin op_class = CLS_JAL;    imm_sel = IMM_J; end
      default: begin op_class = CLS_ILLEGAL; imm_sel = IMM_ZERO; end
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback with
// memory accesses held until mem_rdy_i. Unknown opcodes park in a sticky TRAP.
// Build option: EBREAK_HALT_EN makes EBREAK enter HALT until resume_i;
// without it every SYSTEM opcode is a NOP and halted_o stays low.
module instr_sequencer
  import rv32_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input logic                 clk_i,
  input logic                 reset_i,
  instr_sequencer_if.master   bus
);

  state_t      state_r, state_s;
  op_class_t   class_r, cls_dec_s;
  imm_sel_t    imm_sel_r, imm_dec_s, imm_sel_s;
  logic        illegal_r;
  logic        pc_ld_s, ir_ld_s, mem_rd_s, mem_wr_s, addr_src_s, rf_wr_s, halted_s;
  alu_src_t    alu_a_s;
  alu_b_src_t  alu_b_s;
  alu_op_t     alu_op_s;
  result_src_t result_src_s;

  opcode_classifier #(.DATA_WIDTH(DATA_WIDTH)) u_classifier (
    .ir       (bus.ir_i),
    .op_class (cls_dec_s),
    .imm_sel  (imm_dec_s)
  );

  // State register; reset overrides any outstanding memory request
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= ST_RESET;
    else         state_r <= state_s;
  end

  // Capture instruction class and immediate select during DECODE
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      class_r   <= CLS_ILLEGAL;
      imm_sel_r <= IMM_I;
    end else if (state_r == ST_DECODE) begin
      class_r   <= cls_dec_s;
      imm_sel_r <= imm_dec_s;
    end else begin
      class_r   <= class_r;
      imm_sel_r <= imm_sel_r;
    end
  end

  // Sticky illegal flag, set on the way into TRAP and cleared only by reset
  always_ff @(posedge clk_i) begin
    if (reset_i)                                               illegal_r <= 1'b0;
    else if ((state_r == ST_DECODE) && (cls_dec_s == CLS_ILLEGAL)) illegal_r <= 1'b1;
    else                                                       illegal_r <= illegal_r;
  end

  // Next-state and Moore-style datapath control decode
  always_comb begin
    state_s      = state_r;
    pc_ld_s      = 1'b0;
    ir_ld_s      = 1'b0;
    mem_rd_s     = 1'b0;
    mem_wr_s     = 1'b0;
    addr_src_s   = 1'b0;
    rf_wr_s      = 1'b0;
    halted_s     = 1'b0;
    alu_a_s      = ALU_A_PC;
    alu_b_s      = ALU_B_RS2;
    alu_op_s     = ALU_ADD;
    imm_sel_s    = IMM_I;
    result_src_s = RES_ALU;
    case (state_r)
      ST_RESET: state_s = ST_FETCH;
      ST_FETCH: begin
        mem_rd_s = 1'b1;
        if (bus.mem_rdy_i) begin
          ir_ld_s = 1'b1;
          pc_ld_s = 1'b1;
          alu_b_s = ALU_B_FOUR;
          state_s = ST_DECODE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        imm_sel_s = imm_dec_s;
        alu_a_s   = ALU_A_OLD_PC;
        alu_b_s   = ALU_B_IMM;
        state_s   = (cls_dec_s == CLS_ILLEGAL) ? ST_TRAP : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        imm_sel_s = imm_sel_r;
        case (class_r)
          CLS_ALU: begin
            alu_op_s = ALU_FUNCT;
            alu_a_s  = ALU_A_RS1;
            alu_b_s  = (imm_sel_r == IMM_ZERO) ? ALU_B_RS2 : ALU_B_IMM;
            state_s  = ST_WB;
          end
          CLS_LOAD:   begin alu_a_s = ALU_A_RS1; alu_b_s = ALU_B_IMM; state_s = ST_MEM_RD; end
          CLS_STORE:  begin alu_a_s = ALU_A_RS1; alu_b_s = ALU_B_IMM; state_s = ST_MEM_WR; end
          CLS_BRANCH: begin
            alu_op_s = ALU_SUB;
            alu_a_s  = ALU_A_RS1;
            pc_ld_s  = bus.branch_take_i;
            state_s  = ST_FETCH;
          end
          CLS_JAL:    begin pc_ld_s = 1'b1; state_s = ST_WB; end
          CLS_JALR:   begin pc_ld_s = 1'b1; alu_a_s = ALU_A_RS1; alu_b_s = ALU_B_IMM; state_s = ST_WB; end
          CLS_UPPER:  begin alu_a_s = ALU_A_OLD_PC; alu_b_s = ALU_B_IMM; state_s = ST_WB; end
          CLS_SYSTEM: state_s = ST_FETCH;
`ifdef EBREAK_HALT_EN
          CLS_EBREAK: state_s = ST_HALT;
`else
          CLS_EBREAK: state_s = ST_FETCH;
`endif
          default:    state_s = ST_TRAP;
        endcase
      end
      ST_MEM_RD: begin
        imm_sel_s  = imm_sel_r;
        mem_rd_s   = 1'b1;
        addr_src_s = 1'b1;
        state_s    = bus.mem_rdy_i ? ST_WB : ST_MEM_RD;
      end
      ST_MEM_WR: begin
        imm_sel_s  = imm_sel_r;
        mem_wr_s   = 1'b1;
        addr_src_s = 1'b1;
        state_s    = bus.mem_rdy_i ? ST_FETCH : ST_MEM_WR;
      end
      ST_WB: begin
        imm_sel_s = imm_sel_r;
        rf_wr_s   = 1'b1;
        case (class_r)
          CLS_LOAD:          result_src_s = RES_MEM;
          CLS_JAL, CLS_JALR: result_src_s = RES_PC4;
          default:           result_src_s = RES_ALU;
        endcase
        state_s = ST_FETCH;
      end
      ST_TRAP: state_s = ST_TRAP;
`ifdef EBREAK_HALT_EN
      ST_HALT: begin
        halted_s = 1'b1;
        state_s  = bus.resume_i ? ST_FETCH : ST_HALT;
      end
`endif
      default: state_s = ST_RESET;
    endcase
  end

`ifndef EBREAK_HALT_EN
  logic unused_resume_s;
  assign unused_resume_s = bus.resume_i;
`endif

  assign bus.pc_ld_o      = pc_ld_s;
  assign bus.ir_ld_o      = ir_ld_s;
  assign bus.mem_rd_o     = mem_rd_s;
  assign bus.mem_wr_o     = mem_wr_s;
  assign bus.addr_src_o   = addr_src_s;
  assign bus.alu_a_src_o  = alu_a_s;
  assign bus.alu_b_src_o  = alu_b_s;
  assign bus.alu_op_o     = alu_op_s;
  assign bus.imm_sel_o    = imm_sel_s;
  assign bus.result_src_o = result_src_s;
  assign bus.rf_wr_o      = rf_wr_s;
  assign bus.illegal_o    = illegal_r;
  assign bus.halted_o     = halted_s;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer. Inputs change 2 time
// units after the rising edge; outputs are checked 1 time unit later.
module tb_instr_sequencer;
  logic clk_i = 1'b0;
  logic reset_i;
  int   n_assert = 0;
  int   n_fail   = 0;

  instr_sequencer_if bus();

  instr_sequencer #(.DATA_WIDTH(32)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {pc_ld, ir_ld, mem_rd, mem_wr, rf_wr}
  function automatic logic [4:0] strobes();
    return {bus.pc_ld_o, bus.ir_ld_o, bus.mem_rd_o, bus.mem_wr_o, bus.rf_wr_o};
  endfunction

  function automatic logic [18:0] all_outs();
    return {bus.pc_ld_o, bus.ir_ld_o, bus.mem_rd_o, bus.mem_wr_o, bus.addr_src_o,
            bus.alu_a_src_o, bus.alu_b_src_o, bus.alu_op_o, bus.imm_sel_o,
            bus.result_src_o, bus.rf_wr_o, bus.illegal_o, bus.halted_o};
  endfunction

  task automatic nxt();
    @(posedge clk_i);
    #2;
  endtask

  // In FETCH with mem_rdy_i=1: fetch completes this cycle, then advance to DECODE
  task automatic fetch_done(input string tag);
    #1;
    chk({tag, "_fetch_strb"}, 32'(strobes()), 32'b11100);
    chk({tag, "_fetch_addr"}, 32'(bus.addr_src_o), 32'd0);
    chk({tag, "_fetch_alub"}, 32'(bus.alu_b_src_o), 32'd2);
    chk({tag, "_fetch_alua"}, 32'(bus.alu_a_src_o), 32'd0);
    nxt();
  endtask

  initial begin
    reset_i          = 1'b1;
    bus.ir_i         = 32'h0000_0013;
    bus.mem_rdy_i    = 1'b0;
    bus.branch_take_i = 1'b0;
    bus.resume_i     = 1'b0;
    nxt(); nxt();
    #1 chk("reset_all_zero", 32'(all_outs()), 32'd0);

    // Leave reset and wait in FETCH without rdy
    reset_i = 1'b0;
    nxt(); #1;
    chk("fetch_wait_strb", 32'(strobes()), 32'b00100);
    nxt(); #1;
    chk("fetch_wait_hold", 32'(strobes()), 32'b00100);

    // Reset for 3 cycles mid-wait, with a ready arriving: reset wins
    reset_i = 1'b1; bus.mem_rdy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk("reset_mid_fetch", 32'(all_outs()), 32'd0);
    end
    reset_i = 1'b0; #1;
    chk("post_reset_c1", 32'(all_outs()), 32'd0);
    nxt(); #1;
    chk("post_reset_c2_fetch", 32'(bus.mem_rd_o), 32'd1);

    // ADDI x1,x0,5 with immediate rdy: FETCH, DECODE, EXECUTE, WB
    bus.ir_i = 32'h0050_0093;
    fetch_done("addi");
    #1;
    chk("addi_dec_imm", 32'(bus.imm_sel_o), 32'd0);
    chk("addi_dec_ops", 32'({bus.alu_a_src_o, bus.alu_b_src_o}), 32'b1001);
    chk("addi_dec_strb", 32'(strobes()), 32'd0);
    nxt(); #1;
    chk("addi_ex_op", 32'(bus.alu_op_o), 32'd2);
    chk("addi_ex_imm", 32'(bus.imm_sel_o), 32'd0);
    chk("addi_ex_strb", 32'(strobes()), 32'd0);
    nxt(); #1;
    chk("addi_wb_strb", 32'(strobes()), 32'b00001);
    chk("addi_wb_res", 32'(bus.result_src_o), 32'd0);
    nxt(); #1;
    chk("addi_back_fetch", 32'(strobes()), 32'b11100);

    // LW with rdy delayed 3 cycles in MEM_RD
    bus.ir_i = 32'h0000_A103;
    fetch_done("lw");
    bus.mem_rdy_i = 1'b0; #1;
    chk("lw_dec_imm", 32'(bus.imm_sel_o), 32'd0);
    nxt(); #1;
    chk("lw_ex_ops", 32'({bus.alu_a_src_o, bus.alu_b_src_o, bus.alu_op_o}), 32'b010100);
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      chk("lw_memrd_wait", 32'({strobes(), bus.addr_src_o}), 32'b001001);
    end
    nxt();
    bus.mem_rdy_i = 1'b1; #1;
    chk("lw_memrd_rdy", 32'({strobes(), bus.addr_src_o}), 32'b001001);
    nxt(); #1;
    chk("lw_wb", 32'({strobes(), bus.result_src_o}), 32'b0000101);
    nxt();

    // SW with immediate rdy
    bus.ir_i = 32'h0020_A023;
    fetch_done("sw");
    #1 chk("sw_dec_imm", 32'(bus.imm_sel_o), 32'd1);
    nxt(); nxt(); #1;
    chk("sw_memwr", 32'({strobes(), bus.addr_src_o}), 32'b000101);
    nxt(); #1;
    chk("sw_back_fetch", 32'(bus.mem_rd_o), 32'd1);

    // BEQ taken then not taken
    bus.ir_i = 32'h0020_8463;
    bus.branch_take_i = 1'b1;
    fetch_done("beq_t");
    #1 chk("beq_dec_imm", 32'(bus.imm_sel_o), 32'd2);
    nxt(); #1;
    chk("beq_t_ex", 32'({strobes(), bus.alu_op_o, bus.imm_sel_o}), 32'b1000001010);
    nxt(); #1;
    chk("beq_t_fetch", 32'(bus.mem_rd_o), 32'd1);
    bus.branch_take_i = 1'b0;
    fetch_done("beq_n");
    nxt(); #1;
    chk("beq_n_ex", 32'({strobes(), bus.alu_op_o}), 32'b0000001);
    nxt(); #1;
    chk("beq_n_fetch", 32'(bus.mem_rd_o), 32'd1);

    // SLLI uses shamt immediate
    bus.ir_i = 32'h0010_9093;
    fetch_done("slli");
    #1 chk("slli_dec_imm", 32'(bus.imm_sel_o), 32'd5);
    nxt(); #1;
    chk("slli_ex", 32'({bus.imm_sel_o, bus.alu_op_o}), 32'b10110);
    nxt(); nxt();

    // EBREAK
    bus.ir_i = 32'h0010_0073;
    fetch_done("ebrk");
    #1 chk("ebrk_dec_imm", 32'(bus.imm_sel_o), 32'd0);
    nxt(); nxt(); #1;
`ifdef EBREAK_HALT_EN
    for (int i = 0; i < 3; i++) begin
      chk("ebrk_halted", 32'({strobes(), bus.halted_o}), 32'b000001);
      nxt(); #1;
    end
    bus.resume_i = 1'b1; nxt(); bus.resume_i = 1'b0; #1;
    chk("ebrk_resume_fetch", 32'({strobes(), bus.halted_o}), 32'b111000);
`else
    chk("ebrk_nop_fetch", 32'({strobes(), bus.halted_o}), 32'b111000);
`endif

    // Unknown opcode: TRAP, sticky illegal, no strobes
    bus.ir_i = 32'h0000_007F;
    fetch_done("trap");
    #1 chk("trap_dec_imm", 32'(bus.imm_sel_o), 32'd7);
    for (int i = 0; i < 20; i++) begin
      nxt();
      bus.mem_rdy_i = i[0]; #1;
      chk("trap_quiet", 32'({strobes(), bus.illegal_o}), 32'b000001);
    end
    reset_i = 1'b1;
    nxt(); #1;
    chk("trap_reset_clear", 32'(all_outs()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
